// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   acc_state_t   : state encoding of the signed_accumulator controller
//   acc_cnt_width : width of a beat counter able to hold the value 'count'
package alu_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_DONE  = 2'd2
  } acc_state_t;

  function automatic int acc_cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/signed_adder.sv
// Two's-complement adder, purely combinational.
//   a, b     : SIZE-bit operands
//   result   : SIZE+1-bit sum; result[SIZE] is the carry out of the SIZE-bit add
//   overflow : set when the SIZE-bit sum wrapped modulo 2^SIZE
// The low SIZE bits are the same whether the operands are read as signed or
// unsigned, so the downstream accumulator keeps only those and tracks the wrap
// through 'overflow'.
module signed_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result,
  output logic            overflow
);

  assign result   = {1'b0, a} + {1'b0, b};
  assign overflow = result[SIZE];

endmodule

// File: rtl/signed_accumulator.sv
// Multi-operand add/accumulate stage. Folds COUNT operands, accepted over a
// valid/ready handshake, into a running SIZE-bit sum and presents the sum plus
// a sticky wrap flag on a valid/ready output.
//   clk, reset        : clock, synchronous active-high reset
//   clear             : synchronous abort, returns to IDLE and drops any beat
//   in_valid/in_ready : operand handshake, in_data is the operand
//   out_valid/out_ready : result handshake
//   out_sum           : accumulated sum modulo 2^SIZE
//   out_overflow      : sticky OR of adder overflow over the burst
//
// state     | meaning
// ----------+-----------------------------------------------
// ACC_IDLE  | empty, acc/ovf/cnt are zero, waiting first beat
// ACC_ACCUM | partial burst held, accepting further beats
// ACC_DONE  | result valid and held until out_ready
module signed_accumulator
  import alu_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int COUNT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_sum,
  output logic            out_overflow
);

  localparam int CW = acc_cnt_width(COUNT);

  acc_state_t      state, state_n;
  logic [SIZE-1:0] acc, acc_n;
  logic            ovf, ovf_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [SIZE:0]   add_result;
  logic            add_ovf;
  logic            adder_carry_unused;
  logic            beat;

  signed_adder #(.SIZE(SIZE)) u_adder (
    .a        (acc),
    .b        (in_data),
    .result   (add_result),
    .overflow (add_ovf)
  );

  // The carry only matters through add_ovf; the sum keeps the low SIZE bits.
  assign adder_carry_unused = add_result[SIZE];

  // Handshake outputs are pure state decodes; clear is resolved in next-state.
  assign in_ready     = (state != ACC_DONE);
  assign out_valid    = (state == ACC_DONE);
  assign out_sum      = acc;
  assign out_overflow = ovf;
  assign beat         = in_valid && in_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    unique case (state)
      ACC_IDLE, ACC_ACCUM: begin
        if (beat) begin
          acc_n   = add_result[SIZE-1:0];
          ovf_n   = ovf | add_ovf;
          cnt_n   = cnt + CW'(1);
          state_n = (cnt_n == CW'(COUNT)) ? ACC_DONE : ACC_ACCUM;
        end
      end
      ACC_DONE: begin
        if (out_ready) begin
          state_n = ACC_IDLE;
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ACC_IDLE;
        acc_n   = '0;
        ovf_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
    // Abort wins over any beat or result transfer in the same cycle.
    if (clear) begin
      state_n = ACC_IDLE;
      acc_n   = '0;
      ovf_n   = 1'b0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_signed_accumulator.sv
module tb_signed_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_overflow;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] in_data1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [7:0] out_sum1;
  logic       out_overflow1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  signed_accumulator #(.SIZE(8), .COUNT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  signed_accumulator #(.SIZE(8), .COUNT(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid1),
    .in_ready     (in_ready1),
    .in_data      (in_data1),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .out_sum      (out_sum1),
    .out_overflow (out_overflow1)
  );

  // Reference: add operands as plain integers; any time the running total
  // reaches 256 or more the 8-bit sum wrapped, which sets the sticky flag.
  function automatic logic [8:0] model(input int unsigned ops[4]);
    int unsigned s;
    logic        f;
    s = 0;
    f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = s + ops[i];
      if (s > 255) begin
        f = 1'b1;
        s = s - 256;
      end
    end
    return {f, 8'(s)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, out_sum, out_overflow} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h ovf=%b, want rdy=1 vld=0 sum=00 ovf=0",
               in_ready, out_valid, out_sum, out_overflow);
    end else pass_cnt++;
    total_cnt++;
    if ({in_ready1, out_valid1, out_sum1} !== {1'b1, 1'b0, 8'h00}) begin
      $display("FAIL reset_state_c1: got rdy=%b vld=%b sum=%h, want 1 0 00", in_ready1, out_valid1, out_sum1);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(8'd1);
    beat(8'd2);
    beat(8'd3);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL basic_early_valid: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end else pass_cnt++;
    beat(8'd4);
    total_cnt++;
    if ({out_valid, in_ready, out_sum, out_overflow} !== {1'b1, 1'b0, 8'd10, 1'b0}) begin
      $display("FAIL basic_result: got vld=%b rdy=%b sum=%0d ovf=%b, want 1 0 10 0",
               out_valid, in_ready, out_sum, out_overflow);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL basic_rearm: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    beat(8'hFF);
    beat(8'h01);
    beat(8'h00);
    beat(8'h00);
    total_cnt++;
    if ({out_valid, out_sum, out_overflow} !== {1'b1, 8'h00, 1'b1}) begin
      $display("FAIL wrap_result: got vld=%b sum=%h ovf=%b, want 1 00 1", out_valid, out_sum, out_overflow);
    end else pass_cnt++;
    step();
    beat(8'h00);
    beat(8'h00);
    beat(8'h00);
    beat(8'h01);
    total_cnt++;
    if ({out_valid, out_sum, out_overflow} !== {1'b1, 8'h01, 1'b0}) begin
      $display("FAIL wrap_no_leak: got vld=%b sum=%h ovf=%b, want 1 01 0", out_valid, out_sum, out_overflow);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    beat(8'd10);
    beat(8'd20);
    beat(8'd30);
    beat(8'd40);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      // an operand offered while DONE must not be taken
      in_valid = 1'b1;
      in_data  = 8'd55;
      if ({out_valid, in_ready, out_sum, out_overflow} !== {1'b1, 1'b0, 8'd100, 1'b0}) bad++;
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad != 0 || {out_valid, out_sum} !== {1'b1, 8'd100}) begin
      $display("FAIL backpressure_hold: %0d bad cycles, now vld=%b sum=%0d, want vld=1 sum=100 rdy=0",
               bad, out_valid, out_sum);
    end else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0) begin
      $display("FAIL backpressure_xfer: got vld=%b rdy=%b sum=%0d, want 0 1 0", out_valid, in_ready, out_sum);
    end else pass_cnt++;
  endtask

  task automatic test_clear_gap();
    beat(8'd7);
    step();
    beat(8'd7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd9;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, out_sum, out_overflow} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
      $display("FAIL clear_abort: got vld=%b rdy=%b sum=%0d ovf=%b, want 0 1 0 0",
               out_valid, in_ready, out_sum, out_overflow);
    end else pass_cnt++;
    beat(8'd5);
    step();
    beat(8'd5);
    beat(8'd5);
    step();
    step();
    beat(8'd5);
    total_cnt++;
    if ({out_valid, out_sum, out_overflow} !== {1'b1, 8'd20, 1'b0}) begin
      $display("FAIL clear_gap_result: got vld=%b sum=%0d ovf=%b, want 1 20 0", out_valid, out_sum, out_overflow);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_reset_done();
    out_ready = 1'b0;
    beat(8'd1);
    beat(8'd1);
    beat(8'd1);
    beat(8'd1);
    total_cnt++;
    if ({out_valid, out_sum} !== {1'b1, 8'd4}) begin
      $display("FAIL reset_done_pre: got vld=%b sum=%0d, want 1 4", out_valid, out_sum);
    end else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if ({out_valid, out_sum, in_ready, out_overflow} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
      $display("FAIL reset_done_post: got vld=%b sum=%0d rdy=%b ovf=%b, want 0 0 1 0",
               out_valid, out_sum, in_ready, out_overflow);
    end else pass_cnt++;
    out_ready = 1'b1;
  endtask

  task automatic test_clear_done();
    out_ready = 1'b0;
    beat(8'd200);
    beat(8'd100);
    beat(8'd1);
    beat(8'd2);
    total_cnt++;
    if ({out_valid, out_sum, out_overflow} !== {1'b1, 8'd47, 1'b1}) begin
      $display("FAIL clear_done_pre: got vld=%b sum=%0d ovf=%b, want 1 47 1", out_valid, out_sum, out_overflow);
    end else pass_cnt++;
    out_ready = 1'b1;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    total_cnt++;
    if ({out_valid, out_sum, out_overflow, in_ready} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      $display("FAIL clear_done_post: got vld=%b sum=%0d ovf=%b rdy=%b, want 0 0 0 1",
               out_valid, out_sum, out_overflow, in_ready);
    end else pass_cnt++;
  endtask

  task automatic test_count1();
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    in_data1   = 8'h80;
    step();
    in_valid1  = 1'b0;
    total_cnt++;
    if ({out_valid1, in_ready1, out_sum1, out_overflow1} !== {1'b1, 1'b0, 8'h80, 1'b0}) begin
      $display("FAIL count1_result: got vld=%b rdy=%b sum=%h ovf=%b, want 1 0 80 0",
               out_valid1, in_ready1, out_sum1, out_overflow1);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      $display("FAIL count1_rearm: got vld=%b rdy=%b, want 0 1", out_valid1, in_ready1);
    end else pass_cnt++;
    for (int n = 0; n < 5; n++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      in_valid1 = 1'b1;
      in_data1  = d;
      step();
      in_valid1 = 1'b0;
      total_cnt++;
      if ({out_valid1, out_sum1, out_overflow1} !== {1'b1, d, 1'b0}) begin
        $display("FAIL count1_rand[%0d]: got vld=%b sum=%h ovf=%b, want 1 %h 0",
                 n, out_valid1, out_sum1, out_overflow1, d);
      end else pass_cnt++;
      step();
    end
  endtask

  task automatic test_random();
    int unsigned ops[4];
    logic [8:0]  exp;
    int          stall;
    int          bad;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) ops[i] = $urandom_range(0, 255);
      exp = model(ops);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) step();
        end
        beat(8'(ops[i]));
      end
      stall = $urandom_range(0, 3);
      bad = 0;
      for (int k = 0; k < stall; k++) begin
        if ({out_valid, out_sum, out_overflow} !== {1'b1, exp[7:0], exp[8]}) bad++;
        step();
      end
      total_cnt++;
      if (bad != 0 || {out_valid, in_ready, out_sum, out_overflow} !== {1'b1, 1'b0, exp[7:0], exp[8]}) begin
        $display("FAIL random_burst[%0d]: ops=%0d,%0d,%0d,%0d got vld=%b sum=%h ovf=%b (%0d unstable), want vld=1 sum=%h ovf=%b",
                 n, ops[0], ops[1], ops[2], ops[3], out_valid, out_sum, out_overflow, bad, exp[7:0], exp[8]);
      end else pass_cnt++;
      out_ready = 1'b1;
      step();
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL random_xfer[%0d]: got vld=%b rdy=%b, want 0 1", n, out_valid, in_ready);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear_gap();
    test_reset_done();
    test_clear_done();
    test_count1();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/signed_accumulator.md
# signed_accumulator

Sequential stage directly downstream of `signed_adder`. It accepts a burst of `COUNT` operands over a valid/ready handshake and folds each one into a running sum through an internal `signed_adder` instance. It presents the final sum and a sticky carry/overflow flag on a valid/ready output, then rearms for the next burst. It is the ALU's multi-operand add/accumulate path.

## Interface
Parameters:
- `SIZE`, 8: operand and accumulator width in bits.
- `COUNT`, 4: operands per burst; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort of the current burst.
- `in_valid`  in  1  `in_data` holds an operand.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  `SIZE`  operand.
- `out_valid`  out  1  `out_sum` and `out_overflow` are final.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `SIZE`  accumulated sum, modulo 2^SIZE.
- `out_overflow`  out  1  sticky OR of adder `overflow` over the burst.

## Operation
- Datapath:
  - An internal `signed_adder #(SIZE)` takes `a = acc` and `b = in_data`.
  - On an accepted beat (`in_valid && in_ready`), `acc <= result[SIZE-1:0]` and `ovf <= ovf | overflow`.
  - `result[SIZE]` is discarded from the sum. It appears only through `overflow`.
- Beat counter `cnt`, width `$clog2(COUNT+1)`: cleared in IDLE, incremented per accepted beat.
- States:
  - IDLE: `acc=0`, `ovf=0`, `cnt=0`, `in_ready=1`, `out_valid=0`. An accepted beat goes to ACCUM, or to DONE if `COUNT==1`.
  - ACCUM: `in_ready=1`. A beat that brings `cnt` to `COUNT` goes to DONE. With no beat, it holds.
  - DONE: `in_ready=0`, `out_valid=1`. `out_sum=acc` and `out_overflow=ovf` are held stable. When `out_ready=1`, it goes to IDLE with `acc`, `ovf`, `cnt` zeroed.
- `clear`:
  - From any state, `clear` goes to IDLE and zeroes `acc`, `ovf`, `cnt`.
  - Any beat presented in the same cycle is dropped. `in_ready` stays combinationally 1 in IDLE/ACCUM, but `clear` wins.
  - A `clear` in DONE discards the result even if `out_ready=1`; no transfer counts.
- `reset` has the same effect as `clear` and has highest priority.
- Wrap-around: the sum wraps modulo 2^SIZE; the flag records that a wrap occurred.
- Gaps in `in_valid` are legal at any point within a burst.

## Timing
- Reset values: `in_ready=1` (IDLE), `out_valid=0`, `out_sum=0`, `out_overflow=0`.
- Adder path is combinational into `acc`: one add per cycle, zero stall cycles.
- Latency: `out_valid` rises the cycle after the `COUNT`-th accepted beat. A gap-free burst gives `COUNT+1` cycles from the first beat to `out_valid`.
- Minimum cycles between bursts: `COUNT+1`. The DONE→IDLE handshake cycle cannot also accept an input beat, because `in_ready=0` in DONE.
- `out_valid` never drops without `out_ready`, `clear` or `reset`.
- Outputs are registered or state-decoded. There is no combinational path from `in_valid`/`in_data` to any output.
- `in_ready` depends only on state. `clear` does not gate it combinationally.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum `acc_state_t {ACC_IDLE, ACC_ACCUM, ACC_DONE}`;
  - the beat-counter width function/localparam.
- One sub-module: the existing `signed_adder`, instantiated once as `u_adder`.
- No other hierarchy.

## Test plan
All scenarios use `SIZE=8`, `COUNT=4`.
- Basic burst: beats 1, 2, 3, 4 back-to-back with `out_ready=1` → `out_valid` one cycle after beat 4, `out_sum=8'd10`, `out_overflow=0`, `in_ready` back to 1 the following cycle.
- Wrap: beats 8'hFF, 8'h01, 8'h00, 8'h00 → `out_sum=8'h00`, `out_overflow=1`. The next burst 0,0,0,1 gives `out_sum=1`, `out_overflow=0` (flag not leaked).
- Backpressure: burst 10,20,30,40 with `out_ready=0` for 3 cycles → `out_valid=1`, `out_sum=8'd100` stable, `in_ready=0` throughout. Transfer occurs on the first cycle with `out_ready=1`.
- Gapped input with clear: beats 7, 7, then `clear` with `in_valid=1`, `in_data=9`; then beats 5,5,5,5 → the 9 is dropped, `out_sum=8'd20`, `out_overflow=0`.
- Reset in DONE: complete burst 1,1,1,1 and hold `out_ready=0`, then assert `reset` for one cycle → next cycle `out_valid=0`, `out_sum=0`, `in_ready=1`.
- `COUNT=1` variant: single beat 8'h80 → DONE the next cycle with `out_sum=8'h80`, `out_overflow=0`.
